// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types for the synchronous data memory
package dmem_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } wr_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_clear_seq.sv
// rtl/dmem_clear_seq.sv - post-reset zero-fill sequencer and CLEAR/READY state
module dmem_clear_seq
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     busy,
    output logic                     clr_we,
    output logic [$clog2(DEPTH)-1:0] clr_addr
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    dmem_state_e   state;
    logic [CW-1:0] cnt;

    // Counter parks on the last word so it never walks past DEPTH-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            if (cnt == LAST) begin
                state <= READY;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/dmem_sync.sv
// rtl/dmem_sync.sv - single-port synchronous data memory with zero-fill and pipelined reads
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int       DATA_W  = 8,
    parameter int       ADDR_W  = 8,
    parameter int       DEPTH   = 256,
    parameter int       RD_LAT  = 1,
    parameter wr_mode_e WR_MODE = WRITE_FIRST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              oob
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic          clr_we;
    logic [IW-1:0] clr_addr;

    dmem_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic in_range;
    logic rd_acc;
    logic wr_acc;

    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign rd_acc   = !busy && !reset && mem_read;
    assign wr_acc   = !busy && !reset && mem_write;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [IW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;

    // Single write port: the clear sequence owns it while busy.
    always_comb begin
        we    = clr_we;
        waddr = clr_addr;
        wdata = '0;
        if (!clr_we && wr_acc && in_range) begin
            we    = 1'b1;
            waddr = addr[IW-1:0];
            wdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    logic [DATA_W-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            if (WR_MODE == WRITE_FIRST && mem_write) begin
                rd_word = wr_data;
            end else begin
                rd_word = mem[addr[IW-1:0]];
            end
        end
    end

    logic              s1_rd;
    logic              s1_oob;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_rd   <= 1'b0;
            s1_oob  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_rd  <= rd_acc;
            s1_oob <= (rd_acc || wr_acc) && !in_range;
            if (rd_acc) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_rd;
            logic              s2_oob;
            logic [DATA_W-1:0] s2_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_rd   <= 1'b0;
                    s2_oob  <= 1'b0;
                    s2_data <= '0;
                end else begin
                    s2_rd  <= s1_rd;
                    s2_oob <= s1_oob;
                    if (s1_rd) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_valid = s2_rd;
            assign oob      = s2_oob;
            assign data_out = s2_data;
        end else begin : g_lat1
            assign rd_valid = s1_rd;
            assign oob      = s1_oob;
            assign data_out = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_sync.sv
// tb/tb_dmem_sync.sv - directed self-checking bench over four dmem_sync configurations
module tb_dmem_sync;
    import dmem_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] addr;
    logic [7:0] wr_data;

    logic [7:0] d_data_out, l_data_out, r_data_out, s_data_out;
    logic       d_rd_valid, l_rd_valid, r_rd_valid, s_rd_valid;
    logic       d_busy, l_busy, r_busy, s_busy;
    logic       d_oob, l_oob, r_oob, s_oob;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_sync u_def (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wr_data(wr_data), .data_out(d_data_out),
        .rd_valid(d_rd_valid), .busy(d_busy), .oob(d_oob)
    );

    dmem_sync #(.RD_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wr_data(wr_data), .data_out(l_data_out),
        .rd_valid(l_rd_valid), .busy(l_busy), .oob(l_oob)
    );

    dmem_sync #(.WR_MODE(READ_FIRST)) u_rf (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wr_data(wr_data), .data_out(r_data_out),
        .rd_valid(r_rd_valid), .busy(r_busy), .oob(r_oob)
    );

    dmem_sync #(.DEPTH(200)) u_d200 (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wr_data(wr_data), .data_out(s_data_out),
        .rd_valid(s_rd_valid), .busy(s_busy), .oob(s_oob)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         nd;
        int         ns;
        int         n;
        logic       saw;
        logic [7:0] v;

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wr_data = '0;
        tick;
        tick;
        check("rst_busy", d_busy, 1);
        check("rst_rd_valid", d_rd_valid, 0);
        check("rst_oob", d_oob, 0);
        check("rst_data_out", d_data_out, 0);
        check("rst_lat2_rd_valid", l_rd_valid, 0);

        // Busy duration after reset release, default and DEPTH=200
        reset = 1'b0;
        nd = -1;
        ns = -1;
        for (int i = 1; i <= 600 && (nd < 0 || ns < 0); i++) begin
            tick;
            if (nd < 0 && !d_busy) nd = i;
            if (ns < 0 && !s_busy) ns = i;
        end
        check("clr_cycles_def", nd, 256);
        check("clr_cycles_d200", ns, 200);

        for (int i = 0; i < 256; i++) begin
            addr = 8'(i);
            mem_read = 1'b1;
            tick;
            check("clr_read_zero", {d_rd_valid, d_data_out}, {1'b1, 8'h00});
        end
        mem_read = 1'b0;
        tick;

        // Write then read next cycle, both latencies
        mem_write = 1'b1; addr = 8'h10; wr_data = 8'hA5;
        tick;
        mem_write = 1'b0; mem_read = 1'b1;
        tick;
        mem_read = 1'b0;
        check("wr_rd_def_valid", d_rd_valid, 1);
        check("wr_rd_def_data", d_data_out, 8'hA5);
        check("wr_rd_lat2_early", l_rd_valid, 0);
        tick;
        check("wr_rd_lat2_valid", l_rd_valid, 1);
        check("wr_rd_lat2_data", l_data_out, 8'hA5);
        check("hold_valid", d_rd_valid, 0);
        check("hold_data", d_data_out, 8'hA5);

        // Same-cycle read/write ordering
        mem_write = 1'b1; addr = 8'h20; wr_data = 8'h11;
        tick;
        wr_data = 8'h3C; mem_read = 1'b1;
        tick;
        mem_write = 1'b0;
        check("same_wf_data", {d_rd_valid, d_data_out}, {1'b1, 8'h3C});
        check("same_rf_data", {r_rd_valid, r_data_out}, {1'b1, 8'h11});
        tick;
        mem_read = 1'b0;
        check("next_wf_data", d_data_out, 8'h3C);
        check("next_rf_data", {r_rd_valid, r_data_out}, {1'b1, 8'h3C});

        // Out-of-range accesses on DEPTH=200
        mem_write = 1'b1; addr = 8'hC8; wr_data = 8'h77;
        tick;
        mem_write = 1'b0;
        check("oob_wr_pulse", s_oob, 1);
        check("oob_wr_no_valid", s_rd_valid, 0);
        check("inrange_wr_no_oob", d_oob, 0);
        mem_read = 1'b1;
        tick;
        check("oob_rd_pulse", s_oob, 1);
        check("oob_rd_resp", {s_rd_valid, s_data_out}, {1'b1, 8'h00});
        check("inrange_rd_data", d_data_out, 8'h77);
        check("inrange_rd_no_oob", d_oob, 0);
        addr = 8'h00;
        tick;
        mem_read = 1'b0;
        check("oob_word0_unchanged", {s_rd_valid, s_oob, s_data_out}, {1'b1, 1'b0, 8'h00});
        tick;
        check("oob_pulse_ends", s_oob, 0);

        // Back-to-back reads of 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            mem_write = 1'b1; addr = 8'(i); wr_data = 8'(i * 17);
            tick;
        end
        mem_write = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            mem_read = 1'b1; addr = 8'(i);
            tick;
            v = 8'(i * 17);
            check("b2b_def", {d_rd_valid, d_data_out}, {1'b1, v});
            if (i > 1) begin
                v = 8'((i - 1) * 17);
                check("b2b_lat2", {l_rd_valid, l_data_out}, {1'b1, v});
            end
        end
        mem_read = 1'b0;
        tick;
        check("b2b_lat2_last", {l_rd_valid, l_data_out}, {1'b1, 8'h88});
        check("b2b_def_done", d_rd_valid, 0);

        // Reset during an in-flight read, then reset mid-clear
        mem_read = 1'b1; addr = 8'h10;
        tick;
        mem_read = 1'b0; reset = 1'b1;
        tick;
        check("rst_inflight_lat2", {l_rd_valid, l_data_out}, {1'b0, 8'h00});
        check("rst_def_data", {d_rd_valid, d_data_out}, {1'b0, 8'h00});
        check("rst_busy_next", d_busy, 1);
        reset = 1'b0;
        repeat (100) tick;
        check("busy_mid_clear", d_busy, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        mem_read = 1'b1; addr = 8'h05;
        n = 0;
        saw = 1'b0;
        while (d_busy && n < 1000) begin
            tick;
            n++;
            if (d_rd_valid || d_oob) saw = 1'b1;
        end
        mem_read = 1'b0;
        check("clr_restart_cycles", n, 256);
        check("busy_reads_dropped", saw, 0);
        tick;
        check("ready_no_stale_valid", d_rd_valid, 0);
        mem_read = 1'b1; addr = 8'h10;
        tick;
        mem_read = 1'b0;
        check("recleared_word", {d_rd_valid, d_data_out}, {1'b1, 8'h00});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
